// File: rtl/cdc_hs_tx.sv
// Source-side end of a 4-phase req/ack crossing: accepts words on valid/ready, holds them on
// cdc_data under a level request, and waits for the synchronized acknowledge to rise and fall.
module cdc_hs_tx #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_cdc_req,
    output logic [WIDTH-1:0] o_cdc_data,
    input  logic             i_cdc_ack,
    output logic             o_tx_done,
    output logic             o_busy
);

    typedef enum logic [1:0] {StIdle, StReq, StRelease} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic             r_req;
    logic             w_req_d;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_d;
    logic             r_done;
    logic             w_done_d;
    logic             w_ack_sync;
    logic             w_s_ready;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_ack_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_cdc_ack};
        end
    end

    assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];
    // A stale ack in idle blocks new words until the destination has fully released.
    assign w_s_ready  = (r_state == StIdle) && !w_ack_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_req   <= w_req_d;
            r_data  <= w_data_d;
            r_done  <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_req_d   = r_req;
        w_data_d  = r_data;
        w_done_d  = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_s_valid && w_s_ready) begin
                    w_data_d  = i_s_data;
                    w_req_d   = 1'b1;
                    w_state_d = StReq;
                end
            end
            StReq: begin
                if (w_ack_sync) begin
                    w_req_d   = 1'b0;
                    w_state_d = StRelease;
                end
            end
            StRelease: begin
                if (!w_ack_sync) begin
                    w_done_d  = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_req_d   = 1'b0;
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_s_ready  = w_s_ready;
    assign o_cdc_req  = r_req;
    assign o_cdc_data = r_data;
    assign o_tx_done  = r_done;
    assign o_busy     = (r_state != StIdle);

endmodule
